// File: rtl/sar_search_controller.sv
// Four-bit successive-approximation search controller driving an external combinational
// comparator. Each search presents at most four trial values, MSB first.
module sar_search_controller (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic aBIGGERb,
    input  logic aSMALLERb,
    input  logic aEQUALb,
    output logic b0,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic r0,
    output logic r1,
    output logic r2,
    output logic r3,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic busy,
    output logic done,
    output logic found,
    output logic err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRIAL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_trial;
    logic [3:0]  w_trial;
    logic [1:0]  r_k;
    logic [1:0]  w_k;
    logic [3:0]  r_res;
    logic [3:0]  w_res;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt;
    logic        r_found;
    logic        w_found;
    logic        r_err;
    logic        w_err;
    logic        w_flags_valid;

    // Exactly one of the three comparator flags may be high.
    assign w_flags_valid = (aBIGGERb ^ aSMALLERb ^ aEQUALb) & ~(aBIGGERb & aSMALLERb & aEQUALb);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        w_next_state = r_state;
        w_trial      = r_trial;
        w_k          = r_k;
        w_res        = r_res;
        w_cnt        = r_cnt;
        w_found      = r_found;
        w_err        = r_err;

        case (r_state)
            S_IDLE: begin
                w_trial = 4'b0000;
                if (start) begin
                    w_trial      = 4'b1000;
                    w_k          = 2'd3;
                    w_res        = 4'b0000;
                    w_cnt        = 3'd0;
                    w_found      = 1'b0;
                    w_err        = 1'b0;
                    w_next_state = S_TRIAL;
                end
            end

            S_TRIAL: begin
                w_cnt = r_cnt + 3'd1;
                if (!w_flags_valid) begin
                    w_err        = 1'b1;
                    w_res        = 4'b0000;
                    w_found      = 1'b0;
                    w_trial      = 4'b0000;
                    w_next_state = S_DONE;
                end else if (aEQUALb) begin
                    w_res        = r_trial;
                    w_found      = 1'b1;
                    w_trial      = 4'b0000;
                    w_next_state = S_DONE;
                end else if (r_k == 2'd0) begin
                    // Last bit: "smaller" resolves the result, "bigger" means the flags lied.
                    if (aSMALLERb) begin
                        w_res = {r_trial[3:1], 1'b0};
                    end else begin
                        w_res = r_trial;
                        w_err = 1'b1;
                    end
                    w_trial      = 4'b0000;
                    w_next_state = S_DONE;
                end else begin
                    if (aSMALLERb) begin
                        w_trial[r_k] = 1'b0;
                    end
                    w_trial[r_k - 2'd1] = 1'b1;
                    w_k                 = r_k - 2'd1;
                end
            end

            S_DONE: begin
                w_trial      = 4'b0000;
                w_next_state = S_IDLE;
            end

            default: begin
                w_trial      = 4'b0000;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_trial <= 4'b0000;
            r_k     <= 2'd0;
            r_res   <= 4'b0000;
            r_cnt   <= 3'd0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_trial <= w_trial;
            r_k     <= w_k;
            r_res   <= w_res;
            r_cnt   <= w_cnt;
            r_found <= w_found;
            r_err   <= w_err;
        end
    end

    assign {b3, b2, b1, b0} = r_trial;
    assign {r3, r2, r1, r0} = r_res;
    assign {c2, c1, c0}     = r_cnt;
    assign busy             = (r_state == S_TRIAL);
    assign done             = (r_state == S_DONE);
    assign found            = r_found;
    assign err              = r_err;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench for sar_search_controller: a behavioural comparator answers the trial
// values from a hidden operand, with an override to force illegal flag patterns.
module tb_sar_search_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic aBIGGERb, aSMALLERb, aEQUALb;
    logic b0, b1, b2, b3, r0, r1, r2, r3, c0, c1, c2;
    logic busy, done, found, err;

    logic [3:0] hidden_a = 4'b0000;
    logic       force_en = 1'b0;
    logic [2:0] force_flags = 3'b000;  // {bigger, smaller, equal}

    logic [3:0] b_vec, r_vec;
    logic [2:0] c_vec;

    int total = 0;
    int bad = 0;

    // Observations recorded by the search driver.
    logic [3:0] obs_b [0:8];
    int         obs_n;
    logic       obs_timeout;
    logic       obs_done_early;

    always #5 clk = ~clk;

    assign b_vec = {b3, b2, b1, b0};
    assign r_vec = {r3, r2, r1, r0};
    assign c_vec = {c2, c1, c0};

    assign aBIGGERb  = force_en ? force_flags[2] : (hidden_a > b_vec);
    assign aSMALLERb = force_en ? force_flags[1] : (hidden_a < b_vec);
    assign aEQUALb   = force_en ? force_flags[0] : (hidden_a == b_vec);

    sar_search_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .aBIGGERb(aBIGGERb), .aSMALLERb(aSMALLERb), .aEQUALb(aEQUALb),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .c0(c0), .c1(c1), .c2(c2),
        .busy(busy), .done(done), .found(found), .err(err)
    );

    // Stimulus only: pulse start from IDLE, record each trial value, optionally force the
    // flags on trial index force_at. Returns at the negedge after the last TRIAL cycle.
    task automatic search(input logic [3:0] a, input int force_at, input logic [2:0] fv);
        hidden_a       = a;
        force_en       = 1'b0;
        force_flags    = fv;
        obs_n          = 0;
        obs_timeout    = 1'b0;
        obs_done_early = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && !obs_timeout) begin
            obs_b[obs_n] = b_vec;
            if (done !== 1'b0) obs_done_early = 1'b1;
            force_en = (obs_n == force_at);
            obs_n++;
            if (obs_n > 8) obs_timeout = 1'b1;
            @(negedge clk);
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({b_vec, r_vec, c_vec, busy, done, found, err} !== 15'd0) begin
            bad++;
            $display("FAIL reset_held: got b=%b r=%b c=%b busy=%b done=%b found=%b err=%b, want all zero",
                     b_vec, r_vec, c_vec, busy, done, found, err);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({b_vec, busy, done} !== 6'd0) begin
            bad++;
            $display("FAIL reset_idle: got b=%b busy=%b done=%b, want 0000 0 0", b_vec, busy, done);
        end
    endtask

    task automatic test_found_1011();
        search(4'b1011, -1, 3'b000);
        total++;
        if (obs_n != 4 || obs_b[0] !== 4'b1000 || obs_b[1] !== 4'b1100 ||
            obs_b[2] !== 4'b1010 || obs_b[3] !== 4'b1011 || obs_timeout || obs_done_early) begin
            bad++;
            $display("FAIL seq_1011: got n=%0d b=%b,%b,%b,%b, want n=4 b=1000,1100,1010,1011",
                     obs_n, obs_b[0], obs_b[1], obs_b[2], obs_b[3]);
        end
        total++;
        if ({done, busy, b_vec, r_vec, c_vec, found, err} !== {1'b1, 1'b0, 4'b0000, 4'b1011, 3'b100, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL done_1011: got done=%b busy=%b b=%b r=%b c=%b found=%b err=%b, want 1 0 0000 1011 100 1 0",
                     done, busy, b_vec, r_vec, c_vec, found, err);
        end
        @(negedge clk);
        total++;
        if ({done, busy, r_vec, c_vec, found, err} !== {1'b0, 1'b0, 4'b1011, 3'b100, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL hold_1011: got done=%b busy=%b r=%b c=%b found=%b err=%b, want 0 0 1011 100 1 0",
                     done, busy, r_vec, c_vec, found, err);
        end
    endtask

    task automatic test_all_smaller();
        search(4'b0000, -1, 3'b000);
        total++;
        if (obs_n != 4 || obs_b[0] !== 4'b1000 || obs_b[1] !== 4'b0100 ||
            obs_b[2] !== 4'b0010 || obs_b[3] !== 4'b0001 || obs_timeout || obs_done_early) begin
            bad++;
            $display("FAIL seq_0000: got n=%0d b=%b,%b,%b,%b, want n=4 b=1000,0100,0010,0001",
                     obs_n, obs_b[0], obs_b[1], obs_b[2], obs_b[3]);
        end
        total++;
        if ({done, r_vec, c_vec, found, err} !== {1'b1, 4'b0000, 3'b100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL done_0000: got done=%b r=%b c=%b found=%b err=%b, want 1 0000 100 0 0",
                     done, r_vec, c_vec, found, err);
        end
        @(negedge clk);
    endtask

    task automatic test_first_hit();
        search(4'b1000, -1, 3'b000);
        total++;
        if (obs_n != 1 || obs_b[0] !== 4'b1000 || obs_timeout) begin
            bad++;
            $display("FAIL seq_1000: got n=%0d b=%b, want n=1 b=1000", obs_n, obs_b[0]);
        end
        total++;
        if ({done, r_vec, c_vec, found, err} !== {1'b1, 4'b1000, 3'b001, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL done_1000: got done=%b r=%b c=%b found=%b err=%b, want 1 1000 001 1 0",
                     done, r_vec, c_vec, found, err);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_flags();
        logic [2:0] pat [0:1];
        pat[0] = 3'b110;
        pat[1] = 3'b000;
        for (int i = 0; i < 2; i++) begin
            search(4'b1011, 1, pat[i]);
            total++;
            if (obs_n != 2 || obs_b[0] !== 4'b1000 || obs_b[1] !== 4'b1100 || obs_timeout) begin
                bad++;
                $display("FAIL seq_flags_%b: got n=%0d b=%b,%b, want n=2 b=1000,1100",
                         pat[i], obs_n, obs_b[0], obs_b[1]);
            end
            total++;
            if ({done, r_vec, c_vec, found, err} !== {1'b1, 4'b0000, 3'b010, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL done_flags_%b: got done=%b r=%b c=%b found=%b err=%b, want 1 0000 010 0 1",
                         pat[i], done, r_vec, c_vec, found, err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bigger_at_last_bit();
        search(4'b1111, 3, 3'b100);
        total++;
        if ({obs_n == 4, obs_b[3]} !== {1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL seq_k0_bigger: got n=%0d last b=%b, want n=4 last b=1111", obs_n, obs_b[3]);
        end
        total++;
        if ({done, r_vec, c_vec, found, err} !== {1'b1, 4'b1111, 3'b100, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL done_k0_bigger: got done=%b r=%b c=%b found=%b err=%b, want 1 1111 100 0 1",
                     done, r_vec, c_vec, found, err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_trial();
        int done_seen;
        hidden_a = 4'b1011;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, b_vec} !== {1'b1, 4'b1010}) begin
            bad++;
            $display("FAIL third_trial: got busy=%b b=%b, want 1 1010", busy, b_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({b_vec, r_vec, c_vec, busy, done, found, err} !== 15'd0) begin
            bad++;
            $display("FAIL mid_reset: got b=%b r=%b c=%b busy=%b done=%b found=%b err=%b, want all zero",
                     b_vec, r_vec, c_vec, busy, done, found, err);
        end
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", done_seen);
        end
    endtask

    task automatic test_held_start();
        logic [3:0] exp_b    [0:9];
        logic       exp_busy [0:9];
        logic       exp_done [0:9];
        int         errs;
        int         dones;
        exp_b[0] = 4'b1000; exp_b[1] = 4'b1100; exp_b[2] = 4'b1110; exp_b[3] = 4'b1111;
        exp_b[4] = 4'b0000; exp_b[5] = 4'b0000; exp_b[6] = 4'b1000; exp_b[7] = 4'b1100;
        exp_b[8] = 4'b1110; exp_b[9] = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            exp_busy[i] = !(i == 4 || i == 5);
            exp_done[i] = (i == 4);
        end
        hidden_a = 4'b1111;
        start    = 1'b1;
        errs     = 0;
        dones    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if ({b_vec, busy, done} !== {exp_b[i], exp_busy[i], exp_done[i]}) begin
                errs++;
                $display("FAIL held_start_cycle%0d: got b=%b busy=%b done=%b, want %b %b %b",
                         i, b_vec, busy, done, exp_b[i], exp_busy[i], exp_done[i]);
            end
        end
        start = 1'b0;
        total++;
        if (errs != 0 || dones != 1) begin
            bad++;
            $display("FAIL held_start: got %0d bad cycles, %0d done pulses, want 0 and 1", errs, dones);
        end
        @(negedge clk);
        total++;
        if ({done, r_vec, c_vec, found, err} !== {1'b1, 4'b1111, 3'b100, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL held_second_done: got done=%b r=%b c=%b found=%b err=%b, want 1 1111 100 1 0",
                     done, r_vec, c_vec, found, err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_found_1011();
        test_all_smaller();
        test_first_hit();
        test_bad_flags();
        test_bigger_at_last_bit();
        test_reset_mid_trial();
        test_held_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
